// File: rtl/mbc_bus_sync_if.sv
// Cartridge bus pins and mapper register-write outputs for mbc_bus_sync.
// The master side drives the bus pins; the slave side is the synchronizer.
interface mbc_bus_sync_if;
    logic       n_WR;
    logic       A15;
    logic       A14;
    logic       A13;
    logic [4:0] D;
    logic       REG_WE;
    logic [1:0] REG_SEL;
    logic [4:0] REG_D;
    logic       BUSY;
    logic [7:0] GLITCH_CNT;

    modport master (
        output n_WR, A15, A14, A13, D,
        input  REG_WE, REG_SEL, REG_D, BUSY, GLITCH_CNT
    );

    modport slave (
        input  n_WR, A15, A14, A13, D,
        output REG_WE, REG_SEL, REG_D, BUSY, GLITCH_CNT
    );
endinterface

// File: rtl/mbc_bus_sync.sv
// Cartridge-bus write front end: synchronizes the async pins, qualifies n_WR
// low phases and issues one registered write strobe per valid ROM-area write.
module mbc_bus_sync #(
    parameter int MIN_LOW = 3,
    parameter int CNT_W   = 4
) (
    input logic          CLK,
    input logic          RESET,
    mbc_bus_sync_if.slave bus
);

    typedef enum logic [1:0] {IDLE, COUNT, ARMED, WAIT} state_t;

    state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0] aa_q, aa_d;
    logic [4:0] dd_q, dd_d;
    logic       reg_we_q, reg_we_d;
    logic [1:0] reg_sel_q, reg_sel_d;
    logic [4:0] reg_d_q, reg_d_d;
    logic [7:0] glitch_q, glitch_d;

    logic       wr_s1_q, wr_s1_d, wr_s2_q, wr_s2_d;
    logic [2:0] a_s1_q, a_s1_d, a_s2_q, a_s2_d;
    logic [4:0] d_s1_q, d_s1_d, d_s2_q, d_s2_d;

    logic       addr_ok;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        wr_s1_d = bus.n_WR;
        wr_s2_d = wr_s1_q;
        a_s1_d  = {bus.A15, bus.A14, bus.A13};
        a_s2_d  = a_s1_q;
        d_s1_d  = bus.D;
        d_s2_d  = d_s1_q;
    end

    // The address must stay in the ROM area and match the one latched at the fall.
    assign addr_ok = !a_s2_q[2] && (a_s2_q[1:0] == aa_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        aa_d      = aa_q;
        dd_d      = dd_q;
        reg_we_d  = 1'b0;
        reg_sel_d = reg_sel_q;
        reg_d_d   = reg_d_q;
        glitch_d  = glitch_q;

        if (!wr_s2_q) dd_d = d_s2_q;

        case (state_q)
            IDLE: begin
                if (!wr_s2_q) begin
                    if (!a_s2_q[2]) begin
                        aa_d    = a_s2_q[1:0];
                        cnt_d   = CNT_W'(1);
                        state_d = (MIN_LOW == 1) ? ARMED : COUNT;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            COUNT: begin
                if (wr_s2_q) begin
                    glitch_d = sat_inc(glitch_q);
                    state_d  = IDLE;
                end else if (!addr_ok) begin
                    glitch_d = sat_inc(glitch_q);
                    state_d  = WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(MIN_LOW)) state_d = ARMED;
                end
            end
            ARMED: begin
                if (wr_s2_q) begin
                    reg_we_d  = 1'b1;
                    reg_sel_d = aa_q;
                    reg_d_d   = dd_q;
                    state_d   = IDLE;
                end else if (!addr_ok) begin
                    glitch_d = sat_inc(glitch_q);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (wr_s2_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_s1_q   <= 1'b1;
            wr_s2_q   <= 1'b1;
            a_s1_q    <= '0;
            a_s2_q    <= '0;
            d_s1_q    <= '0;
            d_s2_q    <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            aa_q      <= '0;
            dd_q      <= '0;
            reg_we_q  <= 1'b0;
            reg_sel_q <= '0;
            reg_d_q   <= '0;
            glitch_q  <= '0;
        end else begin
            wr_s1_q   <= wr_s1_d;
            wr_s2_q   <= wr_s2_d;
            a_s1_q    <= a_s1_d;
            a_s2_q    <= a_s2_d;
            d_s1_q    <= d_s1_d;
            d_s2_q    <= d_s2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            aa_q      <= aa_d;
            dd_q      <= dd_d;
            reg_we_q  <= reg_we_d;
            reg_sel_q <= reg_sel_d;
            reg_d_q   <= reg_d_d;
            glitch_q  <= glitch_d;
        end
    end

    assign bus.REG_WE     = reg_we_q;
    assign bus.REG_SEL    = reg_sel_q;
    assign bus.REG_D      = reg_d_q;
    assign bus.BUSY       = (state_q != IDLE);
    assign bus.GLITCH_CNT = glitch_q;

endmodule

// File: tb/tb_mbc_bus_sync.sv
// Self-checking bench for mbc_bus_sync: directed scenarios plus random bus
// traffic against a low-phase-level reference model.
module tb_mbc_bus_sync;
    localparam int MIN_LOW = 3;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    mbc_bus_sync_if bus();

    mbc_bus_sync #(.MIN_LOW(MIN_LOW), .CNT_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state: pins seen through two sample delays, then judged
    // one whole low phase at a time.
    logic       h1_wr = 1'b1, h2_wr = 1'b1;
    logic [2:0] h1_a = '0, h2_a = '0;
    logic [4:0] h1_d = '0, h2_d = '0;
    bit         m_in_low = 0, m_bad = 0;
    int         m_len = 0;
    logic [1:0] m_aa = '0;
    logic [4:0] m_last_d = '0;
    logic       exp_we = 0, exp_busy = 0;
    logic [1:0] exp_sel = '0;
    logic [4:0] exp_d = '0;
    logic [7:0] exp_glitch = '0;

    task automatic model_glitch();
        if (exp_glitch != 8'd255) exp_glitch = exp_glitch + 8'd1;
    endtask

    task automatic model_step();
        logic       s_wr;
        logic [2:0] s_a;
        logic [4:0] s_d;
        if (RESET) begin
            h1_wr = 1'b1; h2_wr = 1'b1; h1_a = '0; h2_a = '0; h1_d = '0; h2_d = '0;
            m_in_low = 0; m_bad = 0; m_len = 0; m_aa = '0; m_last_d = '0;
            exp_we = 0; exp_busy = 0; exp_sel = '0; exp_d = '0; exp_glitch = '0;
        end else begin
            s_wr = h2_wr; s_a = h2_a; s_d = h2_d;
            h2_wr = h1_wr; h2_a = h1_a; h2_d = h1_d;
            h1_wr = bus.n_WR; h1_a = {bus.A15, bus.A14, bus.A13}; h1_d = bus.D;
            exp_we = 0;
            if (!s_wr) begin
                if (!m_in_low) begin
                    m_in_low = 1; m_len = 1; m_aa = s_a[1:0]; m_bad = s_a[2];
                end else begin
                    m_len++;
                    if (!m_bad && (s_a[2] || s_a[1:0] != m_aa)) begin
                        m_bad = 1;
                        model_glitch();
                    end
                end
                m_last_d = s_d;
            end else if (m_in_low) begin
                m_in_low = 0;
                if (!m_bad) begin
                    if (m_len >= MIN_LOW) begin
                        exp_we = 1; exp_sel = m_aa; exp_d = m_last_d;
                    end else begin
                        model_glitch();
                    end
                end
            end
            exp_busy = m_in_low;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic drive(input logic wr, input logic [2:0] a, input logic [4:0] d);
        bus.n_WR = wr;
        {bus.A15, bus.A14, bus.A13} = a;
        bus.D = d;
    endtask

    function automatic logic [16:0] obs();
        return {bus.REG_WE, bus.REG_SEL, bus.REG_D, bus.BUSY, bus.GLITCH_CNT};
    endfunction

    function automatic logic [16:0] expv();
        return {exp_we, exp_sel, exp_d, exp_busy, exp_glitch};
    endfunction

    task automatic pulse_reset();
        RESET = 1'b1;
        step(); step();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 3'b000, 5'h00);
        pulse_reset();
        n_cmp++;
        if (obs() !== 17'h0) begin
            n_fail++; $display("FAIL reset_state: got %h want %h", obs(), 17'h0);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if (obs() !== 17'h0 || obs() !== expv()) begin
                n_fail++; $display("FAIL idle_bus cyc %0d: got %h want 0 (model %h)", i, obs(), expv());
            end
        end
    endtask

    task automatic test_write();
        drive(1'b0, 3'b001, 5'h13);
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL write_low cyc %0d: got %h want %h", i, obs(), expv());
            end
        end
        drive(1'b1, 3'b001, 5'h13);
        for (int k = 1; k <= 5; k++) begin
            step();
            n_cmp++;
            if (bus.REG_WE !== (k == 3)) begin
                n_fail++; $display("FAIL write_latency k=%0d: REG_WE got %b want %b", k, bus.REG_WE, (k == 3));
            end
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL write_rise k=%0d: got %h want %h", k, obs(), expv());
            end
        end
        n_cmp++;
        if ({bus.REG_SEL, bus.REG_D, bus.GLITCH_CNT} !== {2'b01, 5'h13, 8'd0}) begin
            n_fail++; $display("FAIL write_regs: got sel=%b d=%h g=%0d want sel=01 d=13 g=0",
                               bus.REG_SEL, bus.REG_D, bus.GLITCH_CNT);
        end
    endtask

    task automatic test_short_pulse();
        pulse_reset();
        drive(1'b0, 3'b010, 5'h07);
        step(); step();
        drive(1'b1, 3'b010, 5'h07);
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (bus.REG_WE !== 1'b0 || obs() !== expv()) begin
                n_fail++; $display("FAIL short_pulse cyc %0d: got %h want %h", i, obs(), expv());
            end
        end
        n_cmp++;
        if (bus.GLITCH_CNT !== 8'd1) begin
            n_fail++; $display("FAIL short_glitch: got %0d want 1", bus.GLITCH_CNT);
        end
    endtask

    task automatic test_addr_toggle();
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, (i < 3) ? 3'b000 : 3'b010, 5'h0A);
            step();
        end
        drive(1'b1, 3'b010, 5'h0A);
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (bus.REG_WE !== 1'b0 || obs() !== expv()) begin
                n_fail++; $display("FAIL addr_toggle cyc %0d: got %h want %h", i, obs(), expv());
            end
        end
        n_cmp++;
        if (bus.GLITCH_CNT !== 8'd1) begin
            n_fail++; $display("FAIL addr_toggle_glitch: got %0d want 1", bus.GLITCH_CNT);
        end
        drive(1'b0, 3'b011, 5'h02);
        repeat (5) step();
        drive(1'b1, 3'b011, 5'h02);
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL clean_write cyc %0d: got %h want %h", i, obs(), expv());
            end
        end
        n_cmp++;
        if ({bus.REG_SEL, bus.REG_D} !== {2'b11, 5'h02}) begin
            n_fail++; $display("FAIL clean_regs: got sel=%b d=%h want sel=11 d=02", bus.REG_SEL, bus.REG_D);
        end
    endtask

    task automatic test_ram_and_saturate();
        int we_seen;
        we_seen = 0;
        drive(1'b0, 3'b101, 5'h1C);
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.REG_WE) we_seen++;
        end
        drive(1'b1, 3'b101, 5'h1C);
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.REG_WE) we_seen++;
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL ram_write cyc %0d: got %h want %h", i, obs(), expv());
            end
        end
        n_cmp++;
        if (we_seen != 0 || bus.GLITCH_CNT !== 8'd1) begin
            n_fail++; $display("FAIL ram_write_result: we=%0d g=%0d want we=0 g=1", we_seen, bus.GLITCH_CNT);
        end
        for (int p = 0; p < 300; p++) begin
            drive(1'b0, 3'b000, 5'h00);
            step();
            drive(1'b1, 3'b000, 5'h00);
            step(); step();
            if (obs() !== expv()) begin
                n_cmp++; n_fail++;
                $display("FAIL saturate pulse %0d: got %h want %h", p, obs(), expv());
            end
        end
        repeat (3) step();
        n_cmp++;
        if (bus.GLITCH_CNT !== 8'd255 || exp_glitch !== 8'd255) begin
            n_fail++; $display("FAIL saturate: got %0d want 255", bus.GLITCH_CNT);
        end
    endtask

    task automatic test_reset_armed();
        int we_seen;
        we_seen = 0;
        pulse_reset();
        drive(1'b0, 3'b000, 5'h1F);
        repeat (6) step();
        n_cmp++;
        if (bus.BUSY !== 1'b1) begin
            n_fail++; $display("FAIL armed_busy: got %b want 1", bus.BUSY);
        end
        RESET = 1'b1;
        step(); step();
        RESET = 1'b0;
        step();
        drive(1'b1, 3'b000, 5'h1F);
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.REG_WE) we_seen++;
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL reset_armed cyc %0d: got %h want %h", i, obs(), expv());
            end
        end
        n_cmp++;
        if (we_seen != 0 || bus.REG_D !== 5'h00) begin
            n_fail++; $display("FAIL reset_armed_result: we=%0d d=%h want we=0 d=00", we_seen, bus.REG_D);
        end
    endtask

    task automatic test_back_to_back();
        int  we_cnt;
        logic prev_we;
        we_cnt = 0; prev_we = 0;
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < MIN_LOW + 1; i++) begin
                drive((i == MIN_LOW) ? 1'b1 : 1'b0, {1'b0, 2'(p)}, 5'(p + 4));
                step();
                if (bus.REG_WE) we_cnt++;
                n_cmp++;
                if ((prev_we && bus.REG_WE) || obs() !== expv()) begin
                    n_fail++; $display("FAIL back_to_back p=%0d i=%0d: got %h want %h", p, i, obs(), expv());
                end
                prev_we = bus.REG_WE;
            end
        end
        drive(1'b1, 3'b000, 5'h00);
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.REG_WE) we_cnt++;
        end
        n_cmp++;
        if (we_cnt != 6) begin
            n_fail++; $display("FAIL back_to_back_count: got %0d want 6", we_cnt);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 80; t++) begin
            int len, gap, tog_at;
            logic [2:0] a;
            a = {($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3))};
            len = $urandom_range(1, 8);
            tog_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 99;
            gap = $urandom_range(1, 4);
            for (int i = 0; i < len + gap; i++) begin
                if (i == tog_at) a = a ^ 3'(1 << $urandom_range(0, 2));
                drive((i < len) ? 1'b0 : 1'b1, a, 5'($urandom));
                step();
                n_cmp++;
                if (obs() !== expv()) begin
                    n_fail++; $display("FAIL random t=%0d i=%0d: got %h want %h", t, i, obs(), expv());
                end
            end
        end
    endtask

    initial begin
        drive(1'b1, 3'b000, 5'h00);
        test_reset();
        test_write();
        test_short_pulse();
        test_addr_toggle();
        test_ram_and_saturate();
        test_reset_armed();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
